exc_commit_ctrl: RTL and testbench

- WB-stage exception and flush controller; the producer side of the CSR file's exception interface.
- Takes per-instruction exception flags, the ERTN indication and the CSR interrupt request. Drives wb_ex/wb_ecode/wb_esubcode/wb_badvaddr/ertn_flush into the CSR file.
- Generates the pipeline flush and a registered PC redirect toward IF, using a valid/ready handshake.

---
 rtl/exc_commit_ctrl_pkg.sv | 33 +++
 rtl/exc_commit_ctrl_if.sv | 21 ++
 rtl/exc_commit_ctrl_prio_enc.sv | 51 +++++
 rtl/exc_commit_ctrl.sv | 133 +++++++++++++
 tb/tb_exc_commit_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared types for the WB exception/flush controller.
// Exception codes, ADEF subcode, FSM states, badvaddr select, flag bundle.
package exc_commit_ctrl_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [8:0] ESUB_ADEF = 9'd0;

  typedef enum logic {
    ST_IDLE,
    ST_REDIR
  } state_e;

  typedef enum logic [1:0] {
    BADV_NONE,
    BADV_PC,
    BADV_VADDR
  } badv_sel_e;

  typedef struct packed {
    logic adef;
    logic ine;
    logic sys;
    logic brk;
    logic ale;
  } exc_flags_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Redirect handshake from WB controller toward IF.
// master: drives redir_valid/redir_pc, samples redir_ready.
interface exc_commit_ctrl_if #(
  parameter int PC_W = 32
);
  logic            redir_valid;
  logic            redir_ready;
  logic [PC_W-1:0] redir_pc;

  modport master (
    output redir_valid,
    output redir_pc,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_pc,
    output redir_ready
  );
endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Exception priority encoder: INT > ADEF > INE > SYS > BRK > ALE.
// In: valid-gated flags, take_int. Out: exc, ecode, esubcode, badv_sel.
module exc_commit_ctrl_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  exc_flags_t flags,
  input  logic       take_int,
  output logic       exc,
  output logic [5:0] ecode,
  output logic [8:0] esubcode,
  output badv_sel_e  badv_sel
);

  always_comb begin
    exc      = 1'b0;
    ecode    = '0;
    esubcode = '0;
    badv_sel = BADV_NONE;
    priority case (1'b1)
      take_int: begin
        exc   = 1'b1;
        ecode = ECODE_INT;
      end
      flags.adef: begin
        exc      = 1'b1;
        ecode    = ECODE_ADE;
        esubcode = ESUB_ADEF;
        badv_sel = BADV_PC;
      end
      flags.ine: begin
        exc   = 1'b1;
        ecode = ECODE_INE;
      end
      flags.sys: begin
        exc   = 1'b1;
        ecode = ECODE_SYS;
      end
      flags.brk: begin
        exc   = 1'b1;
        ecode = ECODE_BRK;
      end
      flags.ale: begin
        exc      = 1'b1;
        ecode    = ECODE_ALE;
        badv_sel = BADV_VADDR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/ERTN commit, pipeline flush and IF redirect.
// Ports: WB flags/pc/vaddr, CSR int/entry/exit in; CSR pulses, flush, redir if.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int HOLDOFF_CYC = 1,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_valid,
  input  logic [PC_W-1:0] wb_pc,
  input  logic            wb_exc_adef,
  input  logic            wb_exc_ine,
  input  logic            wb_exc_sys,
  input  logic            wb_exc_brk,
  input  logic            wb_exc_ale,
  input  logic [PC_W-1:0] wb_vaddr,
  input  logic            wb_is_ertn,
  input  logic            csr_has_int,
  input  logic [PC_W-1:0] ex_entry,
  input  logic [PC_W-1:0] ex_exit,
  output logic            wb_ex,
  output logic [5:0]      wb_ecode,
  output logic [8:0]      wb_esubcode,
  output logic [PC_W-1:0] wb_badvaddr,
  output logic            ertn_flush,
  output logic            flush,
  output logic            wb_commit_kill,
  exc_commit_ctrl_if.master redir
);

  localparam int HW =
    (HOLDOFF_CYC < 1) ? 1 : $clog2(HOLDOFF_CYC + 1);

  state_e          state_q, state_d;
  logic            kind_ertn_q, kind_ertn_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic       ev;
  logic       take_int;
  logic       exc;
  logic       ertn;
  logic [5:0] ecode;
  logic [8:0] esub;
  exc_flags_t flags;
  badv_sel_e  badv_sel;

  assign ev       = wb_valid & (state_q == ST_IDLE);
  assign take_int = ev & csr_has_int & (hold_cnt_q == '0);

  always_comb begin
    flags = '0;
    if (ev) begin
      flags.adef = wb_exc_adef;
      flags.ine  = wb_exc_ine;
      flags.sys  = wb_exc_sys;
      flags.brk  = wb_exc_brk;
      flags.ale  = wb_exc_ale;
    end
  end

  exc_commit_ctrl_prio_enc u_prio (
    .flags    (flags),
    .take_int (take_int),
    .exc      (exc),
    .ecode    (ecode),
    .esubcode (esub),
    .badv_sel (badv_sel)
  );

  // exception beats ERTN on the same instruction
  assign ertn = ev & wb_is_ertn & ~exc;

  always_comb begin
    wb_badvaddr = '0;
    unique case (badv_sel)
      BADV_PC:    wb_badvaddr = wb_pc;
      BADV_VADDR: wb_badvaddr = wb_vaddr;
      default:    wb_badvaddr = '0;
    endcase
  end

  assign wb_ex          = exc;
  assign wb_ecode       = ecode;
  assign wb_esubcode    = esub;
  assign ertn_flush     = ertn;
  assign wb_commit_kill = exc;
  assign flush          = exc | ertn | (state_q == ST_REDIR);
  assign redir.redir_valid = (state_q == ST_REDIR);
  assign redir.redir_pc    = redir_pc_q;

  always_comb begin
    state_d     = state_q;
    kind_ertn_d = kind_ertn_q;
    redir_pc_d  = redir_pc_q;
    hold_cnt_d  = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HW'(1);
        // target sampled before the CSR file updates at this edge
        if (exc | ertn) begin
          redir_pc_d  = exc ? ex_entry : ex_exit;
          kind_ertn_d = ertn;
          state_d     = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (redir.redir_ready) begin
          state_d = ST_IDLE;
          if (kind_ertn_q) hold_cnt_d = HW'(HOLDOFF_CYC);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      kind_ertn_q <= 1'b0;
      redir_pc_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      kind_ertn_q <= kind_ertn_d;
      redir_pc_q  <= redir_pc_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Randomized + directed bench for exc_commit_ctrl.
// Behavioural model checked every cycle; literal checks pin the model.
module tb_exc_commit_ctrl;

  localparam int HOLD = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_exc_adef, wb_exc_ine, wb_exc_sys;
  logic        wb_exc_brk, wb_exc_ale, wb_is_ertn, csr_has_int;
  logic [31:0] wb_pc, wb_vaddr, ex_entry, ex_exit;
  logic        wb_ex, ertn_flush, flush, wb_commit_kill;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_badvaddr;

  exc_commit_ctrl_if #(.PC_W(32)) rif ();

  exc_commit_ctrl #(.HOLDOFF_CYC(HOLD), .PC_W(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_exc_adef    (wb_exc_adef),
    .wb_exc_ine     (wb_exc_ine),
    .wb_exc_sys     (wb_exc_sys),
    .wb_exc_brk     (wb_exc_brk),
    .wb_exc_ale     (wb_exc_ale),
    .wb_vaddr       (wb_vaddr),
    .wb_is_ertn     (wb_is_ertn),
    .csr_has_int    (csr_has_int),
    .ex_entry       (ex_entry),
    .ex_exit        (ex_exit),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_badvaddr    (wb_badvaddr),
    .ertn_flush     (ertn_flush),
    .flush          (flush),
    .wb_commit_kill (wb_commit_kill),
    .redir          (rif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  bit          m_redir;
  bit          m_ertn_kind;
  logic [31:0] m_pc;
  int          m_hold;

  // samples taken at the negedge of the last tick
  logic        s_ex, s_ertn, s_flush, s_rv;
  logic [5:0]  s_code;
  logic [8:0]  s_sub;
  logic [31:0] s_bad, s_rpc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    wb_valid = 0; wb_exc_adef = 0; wb_exc_ine = 0; wb_exc_sys = 0;
    wb_exc_brk = 0; wb_exc_ale = 0; wb_is_ertn = 0; csr_has_int = 0;
  endtask

  task automatic model_reset();
    m_redir = 0; m_ertn_kind = 0; m_pc = '0; m_hold = 0;
  endtask

  // One cycle: compare at negedge against the model, advance model at posedge.
  task automatic tick();
    bit ev, ti, any, ex, er;
    logic [5:0]  code;
    logic [31:0] bad;
    @(negedge clk);
    ev  = wb_valid && !m_redir;
    ti  = ev && csr_has_int && (m_hold == 0);
    any = wb_exc_adef | wb_exc_ine | wb_exc_sys | wb_exc_brk | wb_exc_ale;
    ex  = ti || (ev && any);
    code = 6'h00;
    bad  = '0;
    if (ex && !ti) begin
      if (wb_exc_adef) begin code = 6'h08; bad = wb_pc; end
      else if (wb_exc_ine) code = 6'h0D;
      else if (wb_exc_sys) code = 6'h0B;
      else if (wb_exc_brk) code = 6'h0C;
      else begin code = 6'h09; bad = wb_vaddr; end
    end
    er = ev && wb_is_ertn && !ex;
    chk("wb_ex", {31'b0, wb_ex}, {31'b0, ex});
    chk("wb_ecode", {26'b0, wb_ecode}, {26'b0, code});
    chk("wb_esubcode", {23'b0, wb_esubcode}, 32'd0);
    chk("wb_badvaddr", wb_badvaddr, bad);
    chk("ertn_flush", {31'b0, ertn_flush}, {31'b0, er});
    chk("wb_commit_kill", {31'b0, wb_commit_kill}, {31'b0, ex});
    chk("flush", {31'b0, flush}, {31'b0, ex || er || m_redir});
    chk("redir_valid", {31'b0, rif.redir_valid}, {31'b0, m_redir});
    chk("redir_pc", rif.redir_pc, m_pc);
    s_ex = wb_ex; s_ertn = ertn_flush; s_flush = flush;
    s_rv = rif.redir_valid; s_code = wb_ecode; s_sub = wb_esubcode;
    s_bad = wb_badvaddr; s_rpc = rif.redir_pc;
    @(posedge clk);
    if (m_redir) begin
      if (rif.redir_ready) begin
        m_redir = 0;
        if (m_ertn_kind) m_hold = HOLD;
      end
    end else begin
      if (m_hold > 0) m_hold--;
      if (ex || er) begin
        m_pc = ex ? ex_entry : ex_exit;
        m_ertn_kind = er;
        m_redir = 1;
      end
    end
    #1;
  endtask

  initial begin
    resetn = 0;
    clear_in();
    wb_pc = '0; wb_vaddr = '0; ex_entry = '0; ex_exit = '0;
    rif.redir_ready = 1;
    model_reset();
    tick();
    chk("reset_flush", {31'b0, s_flush}, 32'd0);
    chk("reset_rv", {31'b0, s_rv}, 32'd0);
    chk("reset_rpc", s_rpc, 32'd0);
    resetn = 1;

    // 1: ALE
    wb_valid = 1; wb_exc_ale = 1; wb_vaddr = 32'h1C000003;
    ex_entry = 32'h1C008000; wb_pc = 32'h1C000000;
    tick();
    chk("t1_ex", {31'b0, s_ex}, 32'd1);
    chk("t1_code", {26'b0, s_code}, 32'h09);
    chk("t1_bad", s_bad, 32'h1C000003);
    chk("t1_flush", {31'b0, s_flush}, 32'd1);
    clear_in();
    tick();
    chk("t1_rv", {31'b0, s_rv}, 32'd1);
    chk("t1_rpc", s_rpc, 32'h1C008000);
    tick();
    chk("t1_idle", {31'b0, s_rv}, 32'd0);

    // 2: priority
    wb_valid = 1; wb_exc_adef = 1; wb_exc_ine = 1; wb_exc_ale = 1;
    wb_pc = 32'h1C000100; wb_vaddr = 32'h0BADBEEF;
    tick();
    chk("t2_code", {26'b0, s_code}, 32'h08);
    chk("t2_sub", {23'b0, s_sub}, 32'd0);
    chk("t2_bad", s_bad, 32'h1C000100);
    clear_in();
    tick();
    wb_valid = 1; wb_exc_adef = 1; wb_exc_ine = 1; wb_exc_ale = 1;
    csr_has_int = 1;
    tick();
    chk("t2i_ex", {31'b0, s_ex}, 32'd1);
    chk("t2i_code", {26'b0, s_code}, 32'h00);
    chk("t2i_bad", s_bad, 32'd0);
    clear_in();
    tick();

    // 5: ERTN + BRK
    wb_valid = 1; wb_is_ertn = 1; wb_exc_brk = 1;
    ex_entry = 32'h1C008000; ex_exit = 32'h11111110;
    tick();
    chk("t5_ex", {31'b0, s_ex}, 32'd1);
    chk("t5_code", {26'b0, s_code}, 32'h0C);
    chk("t5_ertn", {31'b0, s_ertn}, 32'd0);
    clear_in();
    tick();
    chk("t5_rpc", s_rpc, 32'h1C008000);

    // 4: redirect stall after SYS
    wb_valid = 1; wb_exc_sys = 1; ex_entry = 32'h1C00A000;
    rif.redir_ready = 0;
    tick();
    chk("t4_code", {26'b0, s_code}, 32'h0B);
    wb_exc_sys = 0; wb_exc_brk = 1; wb_is_ertn = 1;
    ex_entry = 32'h22222220; ex_exit = 32'h33333330;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rif.redir_ready = 1;
      tick();
      chk("t4_rv", {31'b0, s_rv}, 32'd1);
      chk("t4_flush", {31'b0, s_flush}, 32'd1);
      chk("t4_rpc", s_rpc, 32'h1C00A000);
      chk("t4_noex", {31'b0, s_ex | s_ertn}, 32'd0);
    end
    clear_in();
    tick();
    chk("t4_idle", {31'b0, s_rv}, 32'd0);

    // 3: ERTN with holdoff
    wb_valid = 1; wb_is_ertn = 1; ex_exit = 32'h1C000204;
    tick();
    chk("t3_ertn", {31'b0, s_ertn}, 32'd1);
    chk("t3_ex", {31'b0, s_ex}, 32'd0);
    clear_in();
    tick();
    chk("t3_rpc", s_rpc, 32'h1C000204);
    wb_valid = 1; csr_has_int = 1;
    tick();
    chk("t3_hold", {31'b0, s_ex}, 32'd0);
    tick();
    chk("t3_int", {31'b0, s_ex}, 32'd1);
    chk("t3_icode", {26'b0, s_code}, 32'h00);
    clear_in();
    tick();

    // 6: async reset in REDIR
    wb_valid = 1; wb_exc_sys = 1; rif.redir_ready = 0;
    tick();
    clear_in();
    tick();
    chk("t6_inredir", {31'b0, s_rv}, 32'd1);
    #2 resetn = 0;
    #1;
    chk("t6_rv", {31'b0, rif.redir_valid}, 32'd0);
    chk("t6_flush", {31'b0, flush}, 32'd0);
    chk("t6_ex", {31'b0, wb_ex}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 resetn = 1;
    rif.redir_ready = 1;
    wb_valid = 1; csr_has_int = 1;
    tick();
    chk("t6_hold0", {31'b0, s_ex}, 32'd1);
    clear_in();
    tick();

    // random
    for (int n = 0; n < 800; n++) begin
      wb_valid    = ($urandom_range(0, 3) != 0);
      wb_exc_adef = ($urandom_range(0, 9) == 0);
      wb_exc_ine  = ($urandom_range(0, 9) == 0);
      wb_exc_sys  = ($urandom_range(0, 9) == 0);
      wb_exc_brk  = ($urandom_range(0, 9) == 0);
      wb_exc_ale  = ($urandom_range(0, 9) == 0);
      wb_is_ertn  = ($urandom_range(0, 5) == 0);
      csr_has_int = ($urandom_range(0, 7) == 0);
      rif.redir_ready = ($urandom_range(0, 1) == 1);
      wb_pc    = $urandom;
      wb_vaddr = $urandom;
      ex_entry = $urandom;
      ex_exit  = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
